// File: rtl/read_ecc_correct.sv
// Page-read ECC correction: gathers per-chunk verdicts during compare, then
// applies buffered single-bit fixes to the page RAM by read-modify-write.
module read_ecc_correct #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        page_start,
    input  logic [1:0]  ecc_state,
    input  logic [16:0] change_addr,
    input  logic        ecc_success,
    output logic        ram_en,
    output logic        ram_we,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic        busy,
    output logic        done,
    output logic [1:0]  page_result,
    output logic [6:0]  corr_cnt,
    output logic [5:0]  bad_chunk
);

    localparam int unsigned CNT_W   = FIFO_AW + 1;
    localparam int unsigned ENTRY_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_RD,
        S_LATCH,
        S_WR,
        S_FIN
    } state_e;

    state_e               state_q, state_d;
    logic [ENTRY_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [5:0]           chunk_q, chunk_d;
    logic                 uncorr_q, uncorr_d;
    logic                 ovf_q, ovf_d;
    logic                 ram_en_q, ram_en_d;
    logic                 ram_we_q, ram_we_d;
    logic [12:0]          ram_addr_q, ram_addr_d;
    logic [7:0]           ram_din_q, ram_din_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [1:0]           result_q, result_d;
    logic [6:0]           corr_cnt_q, corr_cnt_d;
    logic [5:0]           bad_chunk_q, bad_chunk_d;
    logic                 push_c;
    logic [FIFO_AW-1:0]   rd_ptr_nx_c;
    logic [ENTRY_W-1:0]   head_c;
    logic [ENTRY_W-1:0]   next_c;
    logic                 fifo_full_c;
    logic                 unused_c;

    // Bit 16 of change_addr carries no information for this block.
    assign unused_c    = change_addr[16];
    assign rd_ptr_nx_c = rd_ptr_q + FIFO_AW'(1);
    assign head_c      = fifo_q[rd_ptr_q];
    assign next_c      = fifo_q[rd_ptr_nx_c];
    assign fifo_full_c = (count_q == CNT_W'(FIFO_DEPTH));

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        chunk_d     = chunk_q;
        uncorr_d    = uncorr_q;
        ovf_d       = ovf_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        corr_cnt_d  = corr_cnt_q;
        bad_chunk_d = bad_chunk_q;
        push_c      = 1'b0;

        if (page_start) begin
            state_d     = S_COLLECT;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            chunk_d     = '0;
            uncorr_d    = 1'b0;
            ovf_d       = 1'b0;
            busy_d      = 1'b0;
            result_d    = 2'd0;
            corr_cnt_d  = '0;
            bad_chunk_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (state_q == S_COLLECT && ecc_state != 2'd0) begin
                        chunk_d = chunk_q + 6'd1;
                        if (ecc_state == 2'd2) begin
                            if (corr_cnt_q != 7'd64) begin
                                corr_cnt_d = corr_cnt_q + 7'd1;
                            end
                            if (fifo_full_c) begin
                                ovf_d = 1'b1;
                            end else begin
                                push_c   = 1'b1;
                                wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
                                count_d  = count_q + CNT_W'(1);
                            end
                        end
                        if (ecc_state == 2'd3) begin
                            if (!uncorr_q) begin
                                bad_chunk_d = chunk_q;
                            end
                            uncorr_d = 1'b1;
                        end
                    end
                    if (ecc_success) begin
                        busy_d = 1'b1;
                        if (uncorr_q || ovf_q) begin
                            result_d = 2'd3;
                            done_d   = 1'b1;
                            state_d  = S_FIN;
                        end else if (count_q == '0) begin
                            result_d = 2'd1;
                            done_d   = 1'b1;
                            state_d  = S_FIN;
                        end else begin
                            ram_en_d   = 1'b1;
                            ram_addr_d = head_c[15:3];
                            state_d    = S_RD;
                        end
                    end
                end
                S_RD: begin
                    state_d = S_LATCH;
                end
                S_LATCH: begin
                    // Read data is valid this cycle; flip the bit on the way to the register.
                    ram_din_d = ram_dout ^ (8'h01 << head_c[2:0]);
                    ram_en_d  = 1'b1;
                    ram_we_d  = 1'b1;
                    state_d   = S_WR;
                end
                S_WR: begin
                    rd_ptr_d = rd_ptr_nx_c;
                    count_d  = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        result_d = 2'd2;
                        done_d   = 1'b1;
                        state_d  = S_FIN;
                    end else begin
                        ram_en_d   = 1'b1;
                        ram_addr_d = next_c[15:3];
                        state_d    = S_RD;
                    end
                end
                S_FIN: begin
                    busy_d  = 1'b0;
                    state_d = S_COLLECT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            chunk_q     <= '0;
            uncorr_q    <= 1'b0;
            ovf_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 2'd0;
            corr_cnt_q  <= '0;
            bad_chunk_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            chunk_q     <= chunk_d;
            uncorr_q    <= uncorr_d;
            ovf_q       <= ovf_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            corr_cnt_q  <= corr_cnt_d;
            bad_chunk_q <= bad_chunk_d;
        end
    end

    // Correction FIFO storage; pointers above gate validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= change_addr[15:0];
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign page_result = result_q;
    assign corr_cnt    = corr_cnt_q;
    assign bad_chunk   = bad_chunk_q;

endmodule
